dmem_bank: RTL and testbench

DMEM_BANK -- requirements
Module: dmem_bank

---
 rtl/dmem_bank.sv | 66 ++++++
 tb/tb_dmem_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
// dmem_bank: single-port 256-bit line memory with a fixed accept-to-ack latency
// and one outstanding request, serving cache line fills and write-backs.
module dmem_bank #(
    parameter int LINE_ADDR_W = 9,
    parameter int LATENCY     = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                 state, state_n;
    logic [7:0]             cnt;
    logic [LINE_ADDR_W-1:0] idx;
    logic [255:0]           wdata;
    logic                   wr;
    logic                   accept;
    logic                   done;
    logic [255:0]           mem [2**LINE_ADDR_W];
    logic                   unused_addr;

    // Offset bits and bits above the index are don't-care, so addresses alias.
    assign unused_addr = ^{addr_i[31:LINE_ADDR_W+5], addr_i[4:0]};
    assign accept      = state == IDLE && enable_i;
    assign done        = state == BUSY && cnt == 8'd1;

    always_comb begin
        state_n = state;
        state_n = accept ? BUSY : done ? ACK : state == ACK ? IDLE : state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            idx    <= '0;
            wdata  <= '0;
            wr     <= 1'b0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            state <= state_n;
            ack_o <= done;
            if (accept) begin
                idx   <= addr_i[LINE_ADDR_W+4:5];
                wdata <= data_i;
                wr    <= write_i;
                cnt   <= 8'(LATENCY - 1);
            end else if (state == BUSY) begin
                cnt <= cnt - 8'd1;
            end
            if (done && !wr) data_o <= mem[idx];
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (done && wr) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: directed and randomized checks of dmem_bank against a
// line-array reference model with fixed-latency completion.
module tb_dmem_bank;
    localparam int L  = 10;
    localparam int AW = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] data = '0;
    logic         ack;
    logic [255:0] rdata;

    dmem_bank #(.LINE_ADDR_W(AW), .LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
        .addr_i(addr), .data_i(data), .ack_o(ack), .data_o(rdata)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int failed = 0;

    logic [255:0] mdl [2**AW];
    bit           known [2**AW];
    int           wq [$];
    logic [255:0] exp_do = '0;

    localparam logic [255:0] PAT_A = {8{32'hA5A5_5A5A}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge
    // after the request has left ACK. Inputs are scrambled while busy, and
    // enable is forced high during the ACK cycle, which must not be accepted.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d);
        int pos = 0;
        int n = 0;
        int li = int'(a[AW+4:5]);
        logic [255:0] ack_data = 'x;
        enable = 1'b1; write = w; addr = a; data = d;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0; write = $urandom; addr = $urandom; data = rnd256();
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                n++;
                if (pos == 0) pos = k;
                ack_data = rdata;
            end
            enable = (k == L - 1) ? 1'b1 : 1'($urandom);
            write = $urandom; addr = $urandom; data = rnd256();
        end
        if (w) begin
            mdl[li] = d;
            if (!known[li]) wq.push_back(li);
            known[li] = 1'b1;
        end else begin
            exp_do = mdl[li];
            chk(w ? "wr_ack_data" : "rd_ack_data", ack_data, exp_do);
        end
        chk("ack_pos", 256'(pos), 256'(L - 1));
        chk("ack_cnt", 256'(n), 256'd1);
        chk("data_o_hold", rdata, exp_do);
    endtask

    task automatic idle();
        enable = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        #1;
        chk("reset_ack", {255'd0, ack}, 256'd0);
        chk("reset_data", rdata, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_req(1'b1, 32'h0000_0400, PAT_A);
        chk("wr_leaves_data_zero", rdata, 256'd0);
        do_req(1'b0, 32'h0000_0400, PAT_A);
        idle();
        repeat (3) @(negedge clk);
        chk("read_held", rdata, PAT_A);
        do_req(1'b1, 32'h0000_0C00, rnd256());
        do_req(1'b1, 32'h0000_0800, rnd256());
        do_req(1'b0, 32'h0000_0C00, '0);
        do_req(1'b0, 32'h0000_4400, '0);
        chk("alias_read", rdata, PAT_A);
        do_req(1'b1, 32'h0000_0020, 256'h1234_5678_9abc);
        do_req(1'b0, 32'h0000_0020, '0);
        // Write a new value to line 1, then reset part-way through.
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0020; data = rnd256();
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_ack", {255'd0, ack}, 256'd0);
        chk("async_rst_data", rdata, 256'd0);
        exp_do = '0;
        n = 0;
        repeat (L + 2) begin
            @(negedge clk);
            if (ack === 1'b1) n++;
        end
        chk("abort_no_ack", 256'(n), 256'd0);
        rst = 1'b0;
        do_req(1'b0, 32'h0000_0020, '0);
        chk("abort_no_write", rdata, 256'h1234_5678_9abc);
        for (int t = 0; t < 40; t++) begin
            if (wq.size() == 0 || ($urandom % 2) == 0) begin
                do_req(1'b1, $urandom, rnd256());
            end else begin
                a = $urandom;
                a[AW+4:5] = AW'(wq[$urandom % wq.size()]);
                do_req(1'b0, a, '0);
            end
            if (($urandom % 4) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
